vga_timing_gen: RTL and testbench

//  Raster timing source for the VGA display path. Derives the pixel-rate enable from clk,

---
 rtl/vga_timing_pkg.sv | 33 +++
 rtl/sync_delay_line.sv | 40 ++++
 rtl/vga_timing_gen.sv | 143 ++++++++++++++
 tb/tb_vga_timing_gen.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared constants and types for the VGA raster timing source.
// Defaults describe 640x480@60 with a 2:1 pixel clock divider.
package vga_timing_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF = 16;
  localparam int H_SYNC_DEF = 96;
  localparam int H_BP_DEF = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF = 10;
  localparam int V_SYNC_DEF = 2;
  localparam int V_BP_DEF = 33;
  localparam bit SYNC_POL_DEF = 1'b0;
  localparam int CLK_DIV_DEF = 2;
  localparam int SYNC_DELAY_DEF = 1;
  localparam int CNT_W = 10;

  typedef struct packed {
    logic active;
    logic hsync;
    logic vsync;
  } sync_t;

  function automatic int total(
    input int a,
    input int p,
    input int s,
    input int b
  );
    return a + p + s + b;
  endfunction

endpackage

// File: rtl/sync_delay_line.sv
// Pixel-rate shift register that realigns sync/active with the
// registered colour path; DEPTH=0 collapses to a wire.
module sync_delay_line
  import vga_timing_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int DEPTH = 1,
  parameter logic [WIDTH-1:0] IDLE = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (DEPTH == 0) begin : g_thru
    logic unused_ok;
    assign unused_ok = &{1'b0, clk, reset_n, en};
    assign q = d;
  end else begin : g_sr
    logic [WIDTH-1:0] sr [DEPTH];

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        for (int i = 0; i < DEPTH; i++) begin
          sr[i] <= IDLE;
        end
      end else if (en) begin
        sr[0] <= d;
        for (int i = 1; i < DEPTH; i++) begin
          sr[i] <= sr[i-1];
        end
      end
    end

    assign q = sr[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing source: pixel enable divider, h/v counters,
// pixel coordinates and delayed sync/active for the colour path.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP = H_FP_DEF,
  parameter int H_SYNC = H_SYNC_DEF,
  parameter int H_BP = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP = V_FP_DEF,
  parameter int V_SYNC = V_SYNC_DEF,
  parameter int V_BP = V_BP_DEF,
  parameter bit SYNC_POL = SYNC_POL_DEF,
  parameter int CLK_DIV = CLK_DIV_DEF,
  parameter int SYNC_DELAY = SYNC_DELAY_DEF
) (
  input  logic       clk,
  input  logic       reset_n,
  output logic       pix_en,
  output logic [9:0] x_px,
  output logic [9:0] y_px,
  output logic       active,
  output logic       hsync,
  output logic       vsync,
  output logic       line_start,
  output logic       frame_start
);

  localparam int H_TOTAL =
    total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL =
    total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int DW =
    (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  if (H_TOTAL > 1024) begin : g_err_h
    $error("H_TOTAL exceeds 1024");
  end
  if (V_TOTAL > 1024) begin : g_err_v
    $error("V_TOTAL exceeds 1024");
  end
  if (CLK_DIV < 1) begin : g_err_div
    $error("CLK_DIV must be >= 1");
  end
  if (SYNC_DELAY > 3 || SYNC_DELAY < 0) begin : g_err_dly
    $error("SYNC_DELAY must be 0..3");
  end

  localparam logic S_IDLE = ~SYNC_POL;
  localparam logic [2:0] IDLE_V = {1'b0, S_IDLE, S_IDLE};

  // 11-bit bounds so a window ending at 1024 still compares
  localparam logic [10:0] H_ACT = 11'(H_ACTIVE);
  localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END =
    11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_ACT = 11'(V_ACTIVE);
  localparam logic [10:0] VS_BEG = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END =
    11'(V_ACTIVE + V_FP + V_SYNC);

  logic [DW-1:0]    div;
  logic             div_last;
  logic [CNT_W-1:0] h;
  logic [CNT_W-1:0] v;
  logic             h_last;
  logic             v_last;
  logic [10:0]      hx;
  logic [10:0]      vx;
  sync_t            raw;
  sync_t            cur;
  sync_t            dly;

  assign div_last = (div == DW'(CLK_DIV - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div <= '0;
      pix_en <= 1'b0;
    end else begin
      pix_en <= div_last;
      div <= div_last ? '0 : div + 1'b1;
    end
  end

  assign h_last = (h == CNT_W'(H_TOTAL - 1));
  assign v_last = (v == CNT_W'(V_TOTAL - 1));
  assign hx = {1'b0, h};
  assign vx = {1'b0, v};

  always_comb begin
    raw = sync_t'(IDLE_V);
    raw.active = (hx < H_ACT) && (vx < V_ACT);
    if (hx >= HS_BEG && hx < HS_END) begin
      raw.hsync = SYNC_POL;
    end
    if (vx >= VS_BEG && vx < VS_END) begin
      raw.vsync = SYNC_POL;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h <= '0;
      v <= '0;
      x_px <= '0;
      y_px <= '0;
      line_start <= 1'b0;
      frame_start <= 1'b0;
      cur <= sync_t'(IDLE_V);
    end else begin
      line_start <= pix_en && (h == '0);
      frame_start <= pix_en && (h == '0) && (v == '0);
      if (pix_en) begin
        x_px <= raw.active ? h : '0;
        y_px <= raw.active ? v : '0;
        cur <= raw;
        h <= h_last ? '0 : h + 1'b1;
        if (h_last) begin
          v <= v_last ? '0 : v + 1'b1;
        end
      end
    end
  end

  sync_delay_line #(
    .WIDTH(3),
    .DEPTH(SYNC_DELAY),
    .IDLE (IDLE_V)
  ) u_dly (
    .clk    (clk),
    .reset_n(reset_n),
    .en     (pix_en),
    .d      (cur),
    .q      (dly)
  );

  assign active = dly.active;
  assign hsync = dly.hsync;
  assign vsync = dly.vsync;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a 14x8 raster: three configurations
// checked against a closed-form raster model plus directed sequences.
module tb_vga_timing_gen;

  localparam int HT = 14;
  localparam int VT = 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] pe, ac, hs, vs, ls, fs;
  logic [9:0] xp [3];
  logic [9:0] yp [3];

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .SYNC_POL(1'b0), .CLK_DIV(2), .SYNC_DELAY(1)
  ) u0 (
    .clk(clk), .reset_n(reset_n), .pix_en(pe[0]),
    .x_px(xp[0]), .y_px(yp[0]), .active(ac[0]),
    .hsync(hs[0]), .vsync(vs[0]),
    .line_start(ls[0]), .frame_start(fs[0])
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .SYNC_POL(1'b0), .CLK_DIV(1), .SYNC_DELAY(0)
  ) u1 (
    .clk(clk), .reset_n(reset_n), .pix_en(pe[1]),
    .x_px(xp[1]), .y_px(yp[1]), .active(ac[1]),
    .hsync(hs[1]), .vsync(vs[1]),
    .line_start(ls[1]), .frame_start(fs[1])
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .SYNC_POL(1'b1), .CLK_DIV(1), .SYNC_DELAY(2)
  ) u2 (
    .clk(clk), .reset_n(reset_n), .pix_en(pe[2]),
    .x_px(xp[2]), .y_px(yp[2]), .active(ac[2]),
    .hsync(hs[2]), .vsync(vs[2]),
    .line_start(ls[2]), .frame_start(fs[2])
  );

  typedef struct packed {
    logic       pe;
    logic [9:0] x;
    logic [9:0] y;
    logic       act;
    logic       hs;
    logic       vs;
    logic       ls;
    logic       fs;
  } obs_t;

  typedef struct {
    int n;
    int x;
    int y;
    int act;
    int hs;
    int vs;
    int ls;
    int fs;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;
  int k = 0;
  int act_cnt = 0;
  int vsl_cnt = 0;
  int fs_cnt = 0;
  int ls_cnt = 0;
  obs_t exp_q[$];
  vec_t tbl [18];

  // k = clk edges since reset release; pixel n appears after
  // edge cd*(n+1)+1, sync fields show pixel n-dl
  function automatic obs_t model(int kk, int cd, int dl,
                                 logic pol);
    obs_t o;
    int n, m, h, v;
    o = '0;
    o.hs = ~pol;
    o.vs = ~pol;
    o.pe = (kk >= 1) && (kk % cd == 0);
    if (kk - 1 >= cd) begin
      n = (kk - 1) / cd - 1;
      h = n % HT;
      v = (n / HT) % VT;
      if (h < 8 && v < 4) begin
        o.x = 10'(h);
        o.y = 10'(v);
      end
      if ((kk - 1) % cd == 0 && h == 0) begin
        o.ls = 1'b1;
        o.fs = (v == 0);
      end
      m = n - dl;
      if (m >= 0) begin
        h = m % HT;
        v = (m / HT) % VT;
        o.act = (h < 8) && (v < 4);
        o.hs = (h >= 10 && h < 13) ? pol : ~pol;
        o.vs = (v >= 5 && v < 7) ? pol : ~pol;
      end
    end
    return o;
  endfunction

  function automatic obs_t sample(int i);
    obs_t o;
    o.pe = pe[i];
    o.x = xp[i];
    o.y = yp[i];
    o.act = ac[i];
    o.hs = hs[i];
    o.vs = vs[i];
    o.ls = ls[i];
    o.fs = fs[i];
    return o;
  endfunction

  always @(posedge clk) begin
    if (!reset_n) k = 0;
    else k = k + 1;
    exp_q.push_back(model(k, 2, 1, 1'b0));
    exp_q.push_back(model(k, 1, 0, 1'b0));
    exp_q.push_back(model(k, 1, 2, 1'b1));
  end

  always @(negedge clk) begin
    obs_t e;
    obs_t g;
    if (exp_q.size() >= 3) begin
      for (int i = 0; i < 3; i++) begin
        e = exp_q.pop_front();
        g = sample(i);
        n_cmp++;
        if (g !== e) begin
          n_bad++;
          $display("FAIL sb_u%0d k=%0d got=%h exp=%h",
                   i, k, g, e);
        end
      end
    end
    if (reset_n && k >= 2 && k <= 113) begin
      act_cnt += int'(ac[1]);
      vsl_cnt += int'(!vs[1]);
      fs_cnt += int'(fs[1]);
      ls_cnt += int'(ls[1]);
    end
  end

  task automatic chk(input string nm, input int got,
                     input int expv);
    n_cmp++;
    if (got != expv) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d",
               nm, got, expv);
    end
  endtask

  task automatic wait_k(input int t);
    for (int i = 0; i < 1000 && k < t; i++) begin
      @(negedge clk);
    end
    if (k < t) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_k: got k=%0d expected %0d", k, t);
    end
  endtask

  initial begin
    tbl[0]  = '{0, 0, 0, 1, 1, 1, 1, 1};
    tbl[1]  = '{1, 1, 0, 1, 1, 1, 0, 0};
    tbl[2]  = '{2, 2, 0, 1, 1, 1, 0, 0};
    tbl[3]  = '{3, 3, 0, 1, 1, 1, 0, 0};
    tbl[4]  = '{4, 4, 0, 1, 1, 1, 0, 0};
    tbl[5]  = '{5, 5, 0, 1, 1, 1, 0, 0};
    tbl[6]  = '{6, 6, 0, 1, 1, 1, 0, 0};
    tbl[7]  = '{7, 7, 0, 1, 1, 1, 0, 0};
    tbl[8]  = '{8, 0, 0, 0, 1, 1, 0, 0};
    tbl[9]  = '{9, 0, 0, 0, 1, 1, 0, 0};
    tbl[10] = '{10, 0, 0, 0, 0, 1, 0, 0};
    tbl[11] = '{11, 0, 0, 0, 0, 1, 0, 0};
    tbl[12] = '{12, 0, 0, 0, 0, 1, 0, 0};
    tbl[13] = '{13, 0, 0, 0, 1, 1, 0, 0};
    tbl[14] = '{17, 3, 1, 1, 1, 1, 0, 0};
    tbl[15] = '{70, 0, 0, 0, 1, 0, 1, 0};
    tbl[16] = '{96, 0, 0, 0, 0, 0, 0, 0};
    tbl[17] = '{112, 0, 0, 1, 1, 1, 1, 1};

    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_pe", int'(pe[0]), 0);
    chk("rst_x", int'(xp[0]), 0);
    chk("rst_y", int'(yp[0]), 0);
    chk("rst_act", int'(ac[0]), 0);
    chk("rst_hs", int'(hs[0]), 1);
    chk("rst_vs", int'(vs[0]), 1);
    chk("rst_ls", int'(ls[0]), 0);
    chk("rst_fs", int'(fs[0]), 0);
    chk("rst_hs_pol1", int'(hs[2]), 0);
    chk("rst_vs_pol1", int'(vs[2]), 0);

    reset_n = 1'b1;
    fork
      begin
        @(negedge clk);
        chk("t1_pe_e1", int'(pe[0]), 0);
        @(negedge clk);
        chk("t1_pe_e2", int'(pe[0]), 1);
        chk("t1_fs_e2", int'(fs[0]), 0);
        @(negedge clk);
        chk("t1_pe_e3", int'(pe[0]), 0);
        chk("t1_fs_e3", int'(fs[0]), 1);
        chk("t1_x_e3", int'(xp[0]), 0);
        chk("t1_y_e3", int'(yp[0]), 0);
        @(negedge clk);
        chk("t1_pe_e4", int'(pe[0]), 1);
        chk("t1_fs_e4", int'(fs[0]), 0);
      end
      begin
        for (int i = 0; i < 18; i++) begin
          wait_k(tbl[i].n + 2);
          chk($sformatf("tbl%0d_x", i), int'(xp[1]), tbl[i].x);
          chk($sformatf("tbl%0d_y", i), int'(yp[1]), tbl[i].y);
          chk($sformatf("tbl%0d_act", i), int'(ac[1]),
              tbl[i].act);
          chk($sformatf("tbl%0d_hs", i), int'(hs[1]), tbl[i].hs);
          chk($sformatf("tbl%0d_vs", i), int'(vs[1]), tbl[i].vs);
          chk($sformatf("tbl%0d_ls", i), int'(ls[1]), tbl[i].ls);
          chk($sformatf("tbl%0d_fs", i), int'(fs[1]), tbl[i].fs);
        end
      end
    join

    wait_k(115);
    chk("t3_act_ticks", act_cnt, 32);
    chk("t3_vsync_low_ticks", vsl_cnt, 28);
    chk("t3_frame_starts", fs_cnt, 1);
    chk("t2_line_starts", ls_cnt, 8);
    chk("t4_act_pre", int'(ac[2]), 0);
    wait_k(116);
    chk("t4_act_rise", int'(ac[2]), 1);
    chk("t4_x_undelayed", int'(xp[2]), 2);
    chk("t4_ref_act", int'(ac[1]), 1);
    wait_k(124);
    chk("t4_ref_hs", int'(hs[1]), 0);
    chk("t4_hs_pre", int'(hs[2]), 0);
    wait_k(126);
    chk("t4_hs_rise", int'(hs[2]), 1);

    wait_k(293);
    chk("t5_x_before", int'(xp[0]), 5);
    chk("t5_y_before", int'(yp[0]), 2);
    #1 reset_n = 1'b0;
    #1;
    chk("t5_x_clr", int'(xp[0]), 0);
    chk("t5_y_clr", int'(yp[0]), 0);
    chk("t5_act_clr", int'(ac[0]), 0);
    chk("t5_hs_clr", int'(hs[0]), 1);
    chk("t5_vs_clr", int'(vs[0]), 1);
    chk("t5_hs_pol1_clr", int'(hs[2]), 0);
    chk("t5_x1_clr", int'(xp[1]), 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    wait_k(3);
    chk("t5_fs_restart", int'(fs[0]), 1);
    chk("t5_x_restart", int'(xp[0]), 0);
    chk("t5_y_restart", int'(yp[0]), 0);
    wait_k(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
